stream_demux: RTL and testbench

Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshaking on every port. Each accepted input beat is steered to one of N_OUT output channels, selected per beat or locked per packet, and held in a one-entry output register per channel until that channel's consumer accepts it. It sits between a single producer and N_OUT independent consumers. It replaces the fixed 1-to-2 gate-level demux with a width-, channel- and mode-generic block that has back-pressure and drop accounting.

---
 rtl/demux_pkg.sv | 12 +
 rtl/stream_demux_if.sv | 25 ++
 rtl/demux_slot.sv | 28 ++
 rtl/stream_demux.sv | 91 +++++++++
 tb/tb_stream_demux.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the stream demultiplexer: packet FSM encoding and
// drop-counter width.
package demux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int DROP_W = 8;

endpackage

// File: rtl/stream_demux_if.sv
// Producer-side and consumer-side stream signals of the 1-to-N demux.
interface stream_demux_if #(
  parameter int WIDTH = 8,
  parameter int N_OUT = 4,
  parameter int SEL_W = $clog2(N_OUT)
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic [SEL_W-1:0]       in_sel;
  logic                   in_last;
  logic [N_OUT-1:0]       out_valid;
  logic [N_OUT-1:0]       out_ready;
  logic [N_OUT*WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, in_sel, in_last, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, in_sel, in_last, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/demux_slot.sv
// One-entry output register of a demux channel; a load wins over a
// simultaneous drain so back-to-back beats flow without a bubble.
module demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_valid && out_ready) begin
      // data is left stale after the drain
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer with per-beat or per-packet select,
// independent per-channel back-pressure and saturating drop accounting.
module stream_demux
  import demux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int N_OUT    = 4,
  parameter int SEL_W    = $clog2(N_OUT),
  parameter int PKT_MODE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  stream_demux_if.slave     bus,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int              N_PAD   = 1 << SEL_W;
  localparam logic [SEL_W:0]  N_OUT_L = (SEL_W + 1)'(N_OUT);
  localparam bit              PKT     = (PKT_MODE != 0);

  state_t                 state_q;
  logic [SEL_W-1:0]       sel_q;
  logic [SEL_W-1:0]       eff_sel;
  logic                   in_range;
  logic [N_PAD-1:0]       free_pad;
  logic                   xfer;
  logic [N_OUT-1:0]       load;
  logic [N_OUT-1:0]       valid_vec;
  logic [N_OUT*WIDTH-1:0] data_vec;

  assign eff_sel  = (PKT && state_q == BUSY) ? sel_q : bus.in_sel;
  assign in_range = ({1'b0, eff_sel} < N_OUT_L);

  // Padded to the full select range so eff_sel always indexes in bounds.
  assign free_pad = N_PAD'(~valid_vec | bus.out_ready);

  assign bus.in_ready = rst_n & (~in_range | free_pad[eff_sel]);
  assign xfer         = bus.in_valid & bus.in_ready;

  assign bus.out_valid = valid_vec;
  assign bus.out_data  = data_vec;

  generate
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_slot
      assign load[gi] = xfer & (eff_sel == SEL_W'(gi));

      demux_slot #(
        .WIDTH(WIDTH)
      ) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load[gi]),
        .load_data (bus.in_data),
        .out_ready (bus.out_ready[gi]),
        .out_valid (valid_vec[gi]),
        .out_data  (data_vec[gi*WIDTH +: WIDTH])
      );
    end
  endgenerate

  // Packet FSM and drop counter; out-of-range beats still advance the FSM so
  // the remainder of a bad packet is dropped too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      drop_cnt <= '0;
    end else begin
      if (xfer && !in_range && drop_cnt != {DROP_W{1'b1}}) begin
        drop_cnt <= drop_cnt + DROP_W'(1);
      end
      if (PKT && xfer) begin
        case (state_q)
          IDLE: begin
            if (!bus.in_last) begin
              state_q <= BUSY;
              sel_q   <= bus.in_sel;
            end
          end
          BUSY: begin
            if (bus.in_last) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: a per-beat 4-channel instance and a packet-mode
// 3-channel instance, checked every cycle against a transfer-level model.
module tb_stream_demux;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_demux_if #(.WIDTH(8), .N_OUT(4)) a_if ();
  stream_demux_if #(.WIDTH(8), .N_OUT(3)) b_if ();
  logic [7:0] a_drop;
  logic [7:0] b_drop;

  stream_demux #(.WIDTH(8), .N_OUT(4), .PKT_MODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if.slave), .drop_cnt(a_drop)
  );
  stream_demux #(.WIDTH(8), .N_OUT(3), .PKT_MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if.slave), .drop_cnt(b_drop)
  );

  // stimulus, index 0 = per-beat instance, 1 = packet instance
  logic       iv[2];
  logic [7:0] idata[2];
  logic [1:0] isel[2];
  logic       ilast[2];
  logic [3:0] ordy[2];

  assign a_if.in_valid  = iv[0];
  assign a_if.in_data   = idata[0];
  assign a_if.in_sel    = isel[0];
  assign a_if.in_last   = ilast[0];
  assign a_if.out_ready = ordy[0];
  assign b_if.in_valid  = iv[1];
  assign b_if.in_data   = idata[1];
  assign b_if.in_sel    = isel[1];
  assign b_if.in_last   = ilast[1];
  assign b_if.out_ready = ordy[1][2:0];

  // reference model: what each channel holds, packet lock, drop total
  int         nout[2] = '{4, 3};
  bit         pkt[2]  = '{1'b0, 1'b1};
  logic [3:0] mv[2];
  logic [7:0] md[2][4];
  bit         mbusy[2];
  logic [1:0] mselq[2];
  int         mdrop[2];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  function automatic logic [1:0] eff(input int d);
    return (pkt[d] && mbusy[d]) ? mselq[d] : isel[d];
  endfunction

  function automatic logic exp_rdy(input int d);
    logic [1:0] s;
    if (!rst_n) return 1'b0;
    s = eff(d);
    if (int'(s) >= nout[d]) return 1'b1;
    return !mv[d][s] || ordy[d][s];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mv[d] = '0;
      for (int k = 0; k < 4; k++) md[d][k] = '0;
      mbusy[d] = 1'b0;
      mselq[d] = '0;
      mdrop[d] = 0;
    end
  endtask

  task automatic model_step();
    logic       rdy;
    logic [1:0] s;
    if (!rst_n) return;
    for (int d = 0; d < 2; d++) begin
      rdy = exp_rdy(d);
      s   = eff(d);
      for (int k = 0; k < nout[d]; k++)
        if (mv[d][k] && ordy[d][k]) mv[d][k] = 1'b0;
      if (iv[d] && rdy) begin
        if (int'(s) < nout[d]) begin
          mv[d][s]    = 1'b1;
          md[d][s]    = idata[d];
          $display("xfer dut%0d data=%02h ch=%0d last=%0b", d, idata[d], s, ilast[d]);
        end else begin
          mdrop[d] = (mdrop[d] < 255) ? mdrop[d] + 1 : 255;
          $display("xfer dut%0d data=%02h dropped sel=%0d drops=%0d", d, idata[d], s, mdrop[d]);
        end
        if (pkt[d]) begin
          if (mbusy[d]) begin
            if (ilast[d]) mbusy[d] = 1'b0;
          end else if (!ilast[d]) begin
            mbusy[d] = 1'b1;
            mselq[d] = isel[d];
          end
        end
      end
    end
  endtask

  task automatic check_model();
    logic [3:0] ov;
    logic [7:0] od[4];
    logic       rdy;
    logic [7:0] dc;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        ov = a_if.out_valid; rdy = a_if.in_ready; dc = a_drop;
        for (int k = 0; k < 4; k++) od[k] = a_if.out_data[k*8 +: 8];
      end else begin
        ov = {1'b0, b_if.out_valid}; rdy = b_if.in_ready; dc = b_drop;
        for (int k = 0; k < 3; k++) od[k] = b_if.out_data[k*8 +: 8];
        od[3] = '0;
      end
      chk("in_ready", d, 32'(rdy), 32'(exp_rdy(d)));
      chk("out_valid", d, 32'(ov), 32'(mv[d]));
      for (int k = 0; k < nout[d]; k++) chk("out_data", d, 32'(od[k]), 32'(md[d][k]));
      chk("drop_cnt", d, 32'(dc), 32'(mdrop[d]));
    end
  endtask

  // one clock: check at the falling edge, advance the model at the rising edge
  task automatic cycle();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input int d, input logic v, input logic [7:0] dat,
                       input logic [1:0] s, input logic l);
    iv[d] = v; idata[d] = dat; isel[d] = s; ilast[d] = l;
  endtask

  initial begin
    logic [7:0] beats[4];
    beats[0] = 8'hA1; beats[1] = 8'hB2; beats[2] = 8'hC3; beats[3] = 8'hD4;
    for (int d = 0; d < 2; d++) begin
      drive(d, 1'b0, 8'h00, 2'd0, 1'b0);
      ordy[d] = 4'h0;
    end
    model_reset();
    #1;
    chk("rst_ready_a", 0, 32'(a_if.in_ready), 32'd0);
    chk("rst_valid_b", 1, 32'(b_if.out_valid), 32'd0);
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();

    // per-beat routing on the 4-channel instance
    ordy[0] = 4'hF;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, beats[i], 2'(i), 1'b0);
      #1;
      chk("route_ready", 0, 32'(a_if.in_ready), 32'd1);
      cycle();
      chk("route_valid", 0, 32'(a_if.out_valid), 32'(4'b0001 << i));
      chk("route_data", 0, 32'(a_if.out_data[i*8 +: 8]), 32'(beats[i]));
    end
    drive(0, 1'b0, 8'h00, 2'd0, 1'b0);
    cycle();

    // packet lock: select 2 held while in_sel wanders
    ordy[1] = 4'h7;
    drive(1, 1'b1, 8'h10, 2'd2, 1'b0); cycle();
    chk("lock_b0", 1, 32'({b_if.out_valid, b_if.out_data[23:16]}), 32'({3'b100, 8'h10}));
    drive(1, 1'b1, 8'h11, 2'd0, 1'b0); cycle();
    chk("lock_b1", 1, 32'({b_if.out_valid, b_if.out_data[23:16]}), 32'({3'b100, 8'h11}));
    drive(1, 1'b1, 8'h12, 2'd1, 1'b1); cycle();
    chk("lock_b2", 1, 32'({b_if.out_valid, b_if.out_data[23:16]}), 32'({3'b100, 8'h12}));
    drive(1, 1'b1, 8'h13, 2'd0, 1'b1); cycle();
    chk("lock_idle", 1, 32'({b_if.out_valid, b_if.out_data[7:0]}), 32'({3'b001, 8'h13}));
    drive(1, 1'b0, 8'h00, 2'd0, 1'b0); cycle();

    // back-pressure on channel 1
    ordy[0] = 4'b1101;
    drive(0, 1'b1, 8'h55, 2'd1, 1'b0); cycle();
    chk("bp_first", 0, 32'({a_if.out_valid[1], a_if.out_data[15:8]}), 32'({1'b1, 8'h55}));
    drive(0, 1'b1, 8'h66, 2'd1, 1'b0); #1;
    chk("bp_stall", 0, 32'(a_if.in_ready), 32'd0);
    cycle();
    chk("bp_hold", 0, 32'({a_if.out_valid[1], a_if.out_data[15:8]}), 32'({1'b1, 8'h55}));
    ordy[0] = 4'hF; #1;
    chk("bp_release", 0, 32'(a_if.in_ready), 32'd1);
    cycle();
    chk("bp_second", 0, 32'({a_if.out_valid[1], a_if.out_data[15:8]}), 32'({1'b1, 8'h66}));
    drive(0, 1'b0, 8'h00, 2'd0, 1'b0); cycle();
    chk("bp_nodup", 0, 32'(a_if.out_valid), 32'd0);

    // independence: channel 0 stalled and full, channel 3 still flows
    ordy[0] = 4'b1110;
    drive(0, 1'b1, 8'h77, 2'd0, 1'b0); cycle();
    drive(0, 1'b1, 8'h88, 2'd0, 1'b0); #1;
    chk("ind_stall", 0, 32'(a_if.in_ready), 32'd0);
    drive(0, 1'b1, 8'h99, 2'd3, 1'b0); #1;
    chk("ind_ready", 0, 32'(a_if.in_ready), 32'd1);
    cycle();
    chk("ind_ch3", 0, 32'({a_if.out_valid, a_if.out_data[31:24], a_if.out_data[7:0]}),
        32'({4'b1001, 8'h99, 8'h77}));
    drive(0, 1'b0, 8'h00, 2'd0, 1'b0);
    ordy[0] = 4'hF;
    cycle();

    // drop: out-of-range select for a 2-beat packet, then saturation
    drive(1, 1'b1, 8'hE0, 2'd3, 1'b0); #1;
    chk("drop_ready", 1, 32'(b_if.in_ready), 32'd1);
    cycle();
    drive(1, 1'b1, 8'hE1, 2'd0, 1'b1); cycle();
    chk("drop_valid", 1, 32'(b_if.out_valid), 32'd0);
    chk("drop_two", 1, 32'(b_drop), 32'd2);
    for (int i = 0; i < 300; i++) begin
      drive(1, 1'b1, 8'(i), 2'd3, 1'b1);
      cycle();
    end
    chk("drop_sat", 1, 32'(b_drop), 32'd255);
    drive(1, 1'b0, 8'h00, 2'd0, 1'b0); cycle();

    // reset in the middle of a 4-beat packet
    drive(1, 1'b1, 8'h21, 2'd2, 1'b0); cycle();
    drive(1, 1'b0, 8'h00, 2'd0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_valid", 1, 32'(b_if.out_valid), 32'd0);
    chk("rst_mid_drop", 1, 32'(b_drop), 32'd0);
    chk("rst_mid_ready", 1, 32'(b_if.in_ready), 32'd0);
    cycle();
    cycle();
    rst_n = 1'b1;
    drive(1, 1'b1, 8'h31, 2'd1, 1'b1); cycle();
    chk("rst_after", 1, 32'({b_if.out_valid, b_if.out_data[15:8]}), 32'({3'b010, 8'h31}));
    drive(1, 1'b0, 8'h00, 2'd0, 1'b0); cycle();

    // randomized traffic on both instances
    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < 2; d++) begin
        drive(d, 1'($urandom_range(0, 1)), 8'($urandom), 2'($urandom_range(0, 3)),
              ($urandom_range(0, 3) == 0));
        ordy[d] = 4'($urandom);
      end
      cycle();
    end
    for (int d = 0; d < 2; d++) drive(d, 1'b0, 8'h00, 2'd0, 1'b0);
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
